max_priority_queue: RTL and testbench
=====================================

// Module: max_priority_queue
// PURPOSE
//  Heap-based max priority queue. Loads a byte stream into an internal array,
//  then executes one command at a time: build heap, extract max, increase value,
//  insert, and dump the array to an external byte RAM.
//  Sits between a stimulus/controller source and a simple write-only RAM
//  (the RAM samples RAM_valid, RAM_A and RAM_D on the negedge of clk).
// PARAMETERS
//  DEPTH  64  max element count; array holds positions 1..DEPTH, DEPTH<=255
// PORTS
//  clk         in   1  single clock; all state updates on the posedge
//  rst         in   1  asynchronous, active-low reset
//  data_valid  in   1  data is appended this cycle
//  data        in   8  unsigned element value
//  cmd_valid   in   1  cmd, index and value are valid; sampled only when busy=0
//  cmd         in   3  000 build, 001 extract, 010 increase, 011 insert, 100 write
//  index       in   8  1-based heap position, used by increase
//  value       in   8  new value, used by increase and insert
//  busy        out  1  command in progress; a new command is only accepted when 0
//  RAM_valid   out  1  RAM write strobe
//  RAM_A       out  8  RAM address
//  RAM_D       out  8  RAM write data
//  done        out  1  write command finished
// BEHAVIOUR
//  - Reset (rst=0): size=0; busy, RAM_valid, RAM_A, RAM_D and done are all 0.
//    An asynchronous reset in the middle of an operation aborts it at once.
//  - Load: on each posedge with data_valid=1, A[size+1]=data and size is
//    incremented. No reordering happens. Writes beyond DEPTH are dropped.
//  - Handshake: when cmd_valid=1 and busy=0 at a posedge, the block latches
//    cmd, index and value, and busy is 1 from that same edge on. busy returns
//    to 0 on the posedge after the command finishes. cmd_valid is ignored
//    while busy=1 or while done=1.
//  - Heapify(i): compare A[i] with its children 2i and 2i+1 that are <= size.
//    Swap A[i] with the largest child if that child is strictly greater, then
//    continue from the child's position. Cost is at most 2 cycles per level.
//    Sift-up(i): while i>1 and A[i/2] < A[i], swap and set i=i/2.
//    Cost is 1 cycle per level.
//  - 000 build: run Heapify(i) for i = size/2 down to 1. With size <= 1 it is a no-op.
//  - 001 extract: A[1]=A[size], size--, then Heapify(1).
//    With size=0 it is a no-op.
//  - 010 increase: if 1 <= index <= size and value >= A[index]:
//    A[index]=value, then Sift-up(index). Otherwise the command is a no-op.
//  - 011 insert: if size < DEPTH: size++, A[size]=value, then Sift-up(size).
//    When full, the command is a no-op.
//  - 100 write: for k=0..size-1, one cycle each, drive RAM_valid=1,
//    RAM_A=k and RAM_D=A[k+1].
//    These outputs are registered, so they are stable across the negedge.
//    Then RAM_valid goes to 0 and done goes to 1 on the next posedge.
//    done stays 1 until reset; busy stays 1 while done is 1.
//  - Unused cmd codes 101..111 cause a 1-cycle busy pulse and nothing else.
//  - All comparisons are unsigned 8-bit; ties never swap.
// CONFIGURATION
//  MPQ_MIN_HEAP_EN defined: every comparison is inverted, so the block is a
//  min-queue. Extract removes the minimum. The increase command lowers the
//  value: it applies only if value <= A[index], then sifts up.
//  MPQ_MIN_HEAP_EN not defined: max-queue exactly as described above.
// TESTING
//  - load 04 01 03 02 10 09 0A 0E 08 07 (hex), build, write
//    -> RAM[0..9] = 10 0E 0A 08 07 09 03 02 04 01, then done=1.
//  - same load, build, extract, write
//    -> RAM[0..8] = 0E 08 0A 04 07 09 03 02 01.
//  - same load, build, insert value=0F, write
//    -> RAM[0..10] = 10 0F 0A 08 0E 09 03 02 04 01 07.
//  - same load, build, increase index=9 value=0F, write
//    -> RAM[0..9] = 10 0F 0A 0E 07 09 03 02 08 01.
//  - handshake: busy=1 on the same edge that accepts cmd_valid; any cmd_valid
//    while busy=1 is ignored. Extract on an empty queue and increase with
//    index=0 leave the array unchanged.
//  - reset: pull rst low mid-build -> all outputs 0 at once; reload and rerun
//    gives the correct result.

Source files
------------

// File: rtl/max_priority_queue.sv
`default_nettype none
// ============================================================================
//  Module      : max_priority_queue
//  Description : Heap-based priority queue over a loadable byte array, with
//                build / extract / increase / insert commands and a dump of
//                the array to a write-only byte RAM. Define MPQ_MIN_HEAP_EN to
//                invert every comparison and obtain a min-queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module max_priority_queue #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] data,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [7:0] index,
  input  logic [7:0] value,
  output logic       busy,
  output logic       RAM_valid,
  output logic [7:0] RAM_A,
  output logic [7:0] RAM_D,
  output logic       done
);

  localparam int AW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] c_depth = AW'(DEPTH);
  localparam logic [AW-1:0] c_root  = AW'(1);

  localparam logic [2:0] c_cmd_build    = 3'b000;
  localparam logic [2:0] c_cmd_extract  = 3'b001;
  localparam logic [2:0] c_cmd_increase = 3'b010;
  localparam logic [2:0] c_cmd_insert   = 3'b011;
  localparam logic [2:0] c_cmd_write    = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_BUILD    = 3'd2,
    S_HEAP     = 3'd3,
    S_SIFT     = 3'd4,
    S_WRITE    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // True when a must sit above b in the heap; ties never outrank.
  function automatic logic f_outranks(input logic [7:0] a, input logic [7:0] b);
`ifdef MPQ_MIN_HEAP_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  state_t        r_state;
  logic [AW-1:0] r_size;
  logic [AW-1:0] r_i;
  logic [AW-1:0] r_bi;
  logic [AW-1:0] r_k;
  logic [2:0]    r_cmd;
  logic [7:0]    r_index;
  logic [7:0]    r_value;
  logic          r_ram_valid;
  logic [7:0]    r_ram_a;
  logic [7:0]    r_ram_d;
  logic          r_done;
  logic [7:0]    r_mem [0:DEPTH];

  state_t        w_state_n;
  logic [AW-1:0] w_size_n;
  logic [AW-1:0] w_i_n;
  logic [AW-1:0] w_bi_n;
  logic [AW-1:0] w_k_n;
  logic          w_ram_valid_n;
  logic [7:0]    w_ram_a_n;
  logic [7:0]    w_ram_d_n;
  logic          w_done_n;

  logic          w_we_a;
  logic [AW-1:0] w_wa_a;
  logic [7:0]    w_wd_a;
  logic          w_we_b;
  logic [AW-1:0] w_wa_b;
  logic [7:0]    w_wd_b;

  logic [AW:0]   w_l;
  logic [AW:0]   w_r;
  logic          w_l_ok;
  logic          w_r_ok;
  logic [7:0]    w_mi;
  logic [7:0]    w_ml;
  logic [7:0]    w_mr;
  logic [AW-1:0] w_p;
  logic [7:0]    w_mp;
  logic [7:0]    w_msz;
  logic [AW-1:0] w_ins_pos;
  logic [AW-1:0] w_idx;
  logic          w_idx_ok;
  logic [7:0]    w_mx;
  logic [7:0]    w_mk;
  logic [AW:0]   w_lg;
  logic [7:0]    w_lgv;

  assign w_l       = {r_i, 1'b0};
  assign w_r       = {r_i, 1'b1};
  assign w_l_ok    = (w_l <= {1'b0, r_size});
  assign w_r_ok    = (w_r <= {1'b0, r_size});
  assign w_mi      = r_mem[r_i];
  assign w_ml      = w_l_ok ? r_mem[w_l[AW-1:0]] : 8'h00;
  assign w_mr      = w_r_ok ? r_mem[w_r[AW-1:0]] : 8'h00;
  assign w_p       = r_i >> 1;
  assign w_mp      = r_mem[w_p];
  assign w_msz     = r_mem[r_size];
  assign w_ins_pos = r_size + c_root;
  assign w_idx     = r_index[AW-1:0];
  assign w_idx_ok  = (r_index != 8'h00) && (r_index <= 8'(r_size));
  assign w_mx      = r_mem[w_idx];
  assign w_mk      = r_mem[r_k + c_root];

  // Heapify step: pick the highest-ranked of node i and its in-range children.
  always_comb begin
    w_lg  = {1'b0, r_i};
    w_lgv = w_mi;
    if (w_l_ok && f_outranks(w_ml, w_lgv)) begin
      w_lg  = w_l;
      w_lgv = w_ml;
    end
    if (w_r_ok && f_outranks(w_mr, w_lgv)) begin
      w_lg  = w_r;
      w_lgv = w_mr;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_size_n      = r_size;
    w_i_n         = r_i;
    w_bi_n        = r_bi;
    w_k_n         = r_k;
    w_ram_valid_n = r_ram_valid;
    w_ram_a_n     = r_ram_a;
    w_ram_d_n     = r_ram_d;
    w_done_n      = r_done;
    w_we_a        = 1'b0;
    w_wa_a        = '0;
    w_wd_a        = 8'h00;
    w_we_b        = 1'b0;
    w_wa_b        = '0;
    w_wd_b        = 8'h00;

    case (r_state)
      S_IDLE: begin
        // Loads are taken only while no command is in flight.
        if (data_valid && (r_size < c_depth)) begin
          w_we_a   = 1'b1;
          w_wa_a   = w_ins_pos;
          w_wd_a   = data;
          w_size_n = w_ins_pos;
        end
        if (cmd_valid) begin
          w_state_n = S_DISPATCH;
        end
      end

      S_DISPATCH: begin
        w_state_n = S_IDLE;
        case (r_cmd)
          c_cmd_build: begin
            w_bi_n    = r_size >> 1;
            w_state_n = S_BUILD;
          end
          c_cmd_extract: begin
            if (r_size != '0) begin
              w_we_a    = 1'b1;
              w_wa_a    = c_root;
              w_wd_a    = w_msz;
              w_size_n  = r_size - c_root;
              w_i_n     = c_root;
              w_state_n = S_HEAP;
            end
          end
          c_cmd_increase: begin
            if (w_idx_ok && !f_outranks(w_mx, r_value)) begin
              w_we_a    = 1'b1;
              w_wa_a    = w_idx;
              w_wd_a    = r_value;
              w_i_n     = w_idx;
              w_state_n = S_SIFT;
            end
          end
          c_cmd_insert: begin
            if (r_size < c_depth) begin
              w_we_a    = 1'b1;
              w_wa_a    = w_ins_pos;
              w_wd_a    = r_value;
              w_size_n  = w_ins_pos;
              w_i_n     = w_ins_pos;
              w_state_n = S_SIFT;
            end
          end
          c_cmd_write: begin
            w_k_n     = '0;
            w_state_n = S_WRITE;
          end
          default: begin
            w_state_n = S_IDLE;
          end
        endcase
      end

      S_BUILD: begin
        if (r_bi == '0) begin
          w_state_n = S_IDLE;
        end else begin
          w_i_n     = r_bi;
          w_state_n = S_HEAP;
        end
      end

      S_HEAP: begin
        if (w_lg != {1'b0, r_i}) begin
          w_we_a = 1'b1;
          w_wa_a = r_i;
          w_wd_a = w_lgv;
          w_we_b = 1'b1;
          w_wa_b = w_lg[AW-1:0];
          w_wd_b = w_mi;
          w_i_n  = w_lg[AW-1:0];
        end else if (r_cmd == c_cmd_build) begin
          w_bi_n    = r_bi - c_root;
          w_state_n = S_BUILD;
        end else begin
          w_state_n = S_IDLE;
        end
      end

      S_SIFT: begin
        if ((r_i > c_root) && f_outranks(w_mi, w_mp)) begin
          w_we_a = 1'b1;
          w_wa_a = w_p;
          w_wd_a = w_mi;
          w_we_b = 1'b1;
          w_wa_b = r_i;
          w_wd_b = w_mp;
          w_i_n  = w_p;
        end else begin
          w_state_n = S_IDLE;
        end
      end

      S_WRITE: begin
        if (r_k < r_size) begin
          w_ram_valid_n = 1'b1;
          w_ram_a_n     = 8'(r_k);
          w_ram_d_n     = w_mk;
          w_k_n         = r_k + c_root;
        end else begin
          w_ram_valid_n = 1'b0;
          w_done_n      = 1'b1;
          w_state_n     = S_DONE;
        end
      end

      S_DONE: begin
        w_state_n = S_DONE;
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_size      <= '0;
      r_i         <= '0;
      r_bi        <= '0;
      r_k         <= '0;
      r_cmd       <= 3'b000;
      r_index     <= 8'h00;
      r_value     <= 8'h00;
      r_ram_valid <= 1'b0;
      r_ram_a     <= 8'h00;
      r_ram_d     <= 8'h00;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_size      <= w_size_n;
      r_i         <= w_i_n;
      r_bi        <= w_bi_n;
      r_k         <= w_k_n;
      r_ram_valid <= w_ram_valid_n;
      r_ram_a     <= w_ram_a_n;
      r_ram_d     <= w_ram_d_n;
      r_done      <= w_done_n;
      if ((r_state == S_IDLE) && cmd_valid) begin
        r_cmd   <= cmd;
        r_index <= index;
        r_value <= value;
      end
    end
  end

  // Array contents need no reset: size=0 makes every stale entry unreachable.
  always_ff @(posedge clk) begin
    if (w_we_a) begin
      r_mem[w_wa_a] <= w_wd_a;
    end
    if (w_we_b) begin
      r_mem[w_wa_b] <= w_wd_b;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign RAM_valid = r_ram_valid;
  assign RAM_A     = r_ram_a;
  assign RAM_D     = r_ram_d;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_max_priority_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_max_priority_queue
//  Description : Directed scoreboard bench for max_priority_queue (max build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_max_priority_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'b000;
  logic [7:0] index = 8'h00;
  logic [7:0] value = 8'h00;
  logic       busy;
  logic       RAM_valid;
  logic [7:0] RAM_A;
  logic [7:0] RAM_D;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ram_t;

  ram_t       exp_q[$];
  logic [7:0] ld_img[$];
  logic [7:0] exp_img[$];
  logic [7:0] base_ld[$];
  logic [7:0] build_exp[$];

  always #5 clk = ~clk;

  max_priority_queue #(.DEPTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .index      (index),
    .value      (value),
    .busy       (busy),
    .RAM_valid  (RAM_valid),
    .RAM_A      (RAM_A),
    .RAM_D      (RAM_D),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every RAM strobe seen at the negedge is matched against the queue.
  always @(negedge clk) begin
    ram_t e;
    if (rst && RAM_valid) begin
      if (exp_q.size() == 0) begin
        check("ram_unexpected_write", {16'h0000, RAM_A, RAM_D}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("ram_addr", {24'h0, RAM_A}, {24'h0, e.a});
        check("ram_data", {24'h0, RAM_D}, {24'h0, e.d});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    data_valid = 1'b0;
    cmd_valid  = 1'b0;
    rst        = 1'b0;
    #2;
    check("rst_busy",      {31'h0, busy},      32'h0);
    check("rst_ram_valid", {31'h0, RAM_valid}, 32'h0);
    check("rst_ram_a",     {24'h0, RAM_A},     32'h0);
    check("rst_ram_d",     {24'h0, RAM_D},     32'h0);
    check("rst_done",      {31'h0, done},      32'h0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic load_img();
    foreach (ld_img[j]) begin
      data_valid = 1'b1;
      data       = ld_img[j];
      tick();
    end
    data_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] idx, input logic [7:0] val);
    cmd_valid = 1'b1;
    cmd       = c;
    index     = idx;
    value     = val;
    tick();
    cmd_valid = 1'b0;
    check("accept_busy", {31'h0, busy}, 32'h1);
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (busy && cyc < 2000) begin
      tick();
      cyc++;
    end
    check(name, {31'h0, busy}, 32'h0);
  endtask

  task automatic run_write();
    int cyc = 0;
    foreach (exp_img[j]) exp_q.push_back(ram_t'({8'(j), exp_img[j]}));
    issue(3'b100, 8'h00, 8'h00);
    while (!done && cyc < 1000) begin
      tick();
      cyc++;
    end
    check("write_done",           {31'h0, done},      32'h1);
    check("write_all_seen",       exp_q.size(),       32'h0);
    check("busy_held_after_done", {31'h0, busy},      32'h1);
    check("ram_valid_after_done", {31'h0, RAM_valid}, 32'h0);
    exp_q.delete();
  endtask

  task automatic load_and_build();
    ld_img = base_ld;
    load_img();
    issue(3'b000, 8'h00, 8'h00);
    wait_idle("build_idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    base_ld   = '{8'h04, 8'h01, 8'h03, 8'h02, 8'h10, 8'h09, 8'h0A, 8'h0E, 8'h08, 8'h07};
    build_exp = '{8'h10, 8'h0E, 8'h0A, 8'h08, 8'h07, 8'h09, 8'h03, 8'h02, 8'h04, 8'h01};

    // Build then dump.
    do_reset();
    load_and_build();
    exp_img = build_exp;
    run_write();

    // Build, extract, dump.
    do_reset();
    load_and_build();
    issue(3'b001, 8'h00, 8'h00);
    wait_idle("extract_idle");
    exp_img = '{8'h0E, 8'h08, 8'h0A, 8'h04, 8'h07, 8'h09, 8'h03, 8'h02, 8'h01};
    run_write();

    // Build, insert 0F, dump.
    do_reset();
    load_and_build();
    issue(3'b011, 8'h00, 8'h0F);
    wait_idle("insert_idle");
    exp_img = '{8'h10, 8'h0F, 8'h0A, 8'h08, 8'h0E, 8'h09, 8'h03, 8'h02, 8'h04, 8'h01, 8'h07};
    run_write();

    // Build, increase index 9 to 0F, dump.
    do_reset();
    load_and_build();
    issue(3'b010, 8'd9, 8'h0F);
    wait_idle("increase_idle");
    exp_img = '{8'h10, 8'h0F, 8'h0A, 8'h0E, 8'h07, 8'h09, 8'h03, 8'h02, 8'h08, 8'h01};
    run_write();

    // Increase no-ops: index 0, smaller value, index beyond size.
    do_reset();
    load_and_build();
    issue(3'b010, 8'd0, 8'hFF);
    wait_idle("inc_idx0_idle");
    issue(3'b010, 8'd1, 8'h05);
    wait_idle("inc_lower_idle");
    issue(3'b010, 8'd11, 8'hFF);
    wait_idle("inc_range_idle");
    exp_img = build_exp;
    run_write();

    // Commands presented while busy are ignored; unused code gives a 1-cycle pulse.
    do_reset();
    ld_img = base_ld;
    load_img();
    issue(3'b000, 8'h00, 8'h00);
    cmd_valid = 1'b1;
    cmd       = 3'b011;
    value     = 8'hFF;
    tick();
    tick();
    cmd_valid = 1'b0;
    check("busy_during_build", {31'h0, busy}, 32'h1);
    wait_idle("build_idle_hs");
    issue(3'b101, 8'h00, 8'h00);
    tick();
    check("unused_busy_pulse", {31'h0, busy}, 32'h0);
    exp_img = build_exp;
    run_write();

    // Extract on an empty queue, then an empty dump.
    do_reset();
    issue(3'b001, 8'h00, 8'h00);
    wait_idle("extract_empty_idle");
    exp_img.delete();
    run_write();

    // Overfill: loads past 64 dropped, insert when full is a no-op.
    do_reset();
    ld_img.delete();
    for (int k = 0; k < 66; k++) ld_img.push_back(8'(k));
    load_img();
    issue(3'b011, 8'h00, 8'hFF);
    wait_idle("insert_full_idle");
    exp_img.delete();
    for (int k = 0; k < 64; k++) exp_img.push_back(8'(k));
    run_write();

    // Asynchronous reset mid-build, then reload and rerun.
    do_reset();
    ld_img = base_ld;
    load_img();
    issue(3'b000, 8'h00, 8'h00);
    tick();
    rst = 1'b0;
    #1;
    check("midbuild_rst_busy", {31'h0, busy}, 32'h0);
    check("midbuild_rst_done", {31'h0, done}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    load_and_build();
    exp_img = build_exp;
    run_write();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
